// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmit engine.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_POP,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD
    } spi_tx_state_t;

endpackage

// File: rtl/spi_master_tx_engine_if.sv
// Byte FIFO read port between the FIFO (slave) and the engine (master).
interface spi_master_tx_engine_if;
    import spi_pkg::*;

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [SPI_BYTE_W-1:0] fifo_rd_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rd_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rd_data
    );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV clk cycles per half-period while run_i is high.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic sck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    logic [7:0] phase_q, phase_d;
    logic       sck_q, sck_d;
    logic       tc;

    assign tc         = run_i && (phase_q == 8'(CLK_DIV - 1));
    assign rise_stb_o = tc && !sck_q;
    assign fall_stb_o = tc && sck_q;
    assign sck_o      = sck_q;

    always_comb begin
        phase_d = phase_q;
        sck_d   = sck_q;
        if (!run_i) begin
            phase_d = '0;
            sck_d   = 1'b0;
        end else if (tc) begin
            phase_d = '0;
            sck_d   = ~sck_q;
        end else begin
            phase_d = phase_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            sck_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sck_q   <= sck_d;
        end
    end

endmodule

// File: rtl/spi_master_tx_engine.sv
// FIFO-draining SPI mode-0 master: pops bytes, shifts them out MSB first
// and assembles the MISO byte received alongside each one.
module spi_master_tx_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    spi_master_tx_engine_if.master fifo,
    input  logic                   spi_miso,
    output logic                   spi_sck,
    output logic                   spi_mosi,
    output logic                   spi_cs_n,
    output logic [SPI_BYTE_W-1:0]  rx_data,
    output logic                   rx_valid,
    output logic                   busy
);

    spi_tx_state_t         state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic [SPI_BYTE_W-1:0] rxs_q, rxs_d;
    logic [SPI_BYTE_W-1:0] rxd_q, rxd_d;
    logic                  cs_n_q, cs_n_d;
    logic                  rd_en_q, rd_en_d;
    logic                  rxv_q, rxv_d;
    logic                  busy_q, busy_d;
    logic                  run, rise, fall, more;

    assign more = en && !fifo.fifo_empty;
    assign run  = (state_q == ST_SHIFT);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .sck_o      (spi_sck),
        .rise_stb_o (rise),
        .fall_stb_o (fall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rxs_d   = rxs_q;
        rxd_d   = rxd_q;
        cs_n_d  = cs_n_q;
        rxv_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (more) begin
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = fifo.fifo_empty ? ST_HOLD : ST_POP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_d    = fifo.fifo_rd_data;
                bit_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (rise) begin
                    rxs_d = {rxs_q[SPI_BYTE_W-2:0], spi_miso};
                end
                // the 8th falling edge ends the byte without a MOSI advance
                if (fall) begin
                    if (bit_q == 3'd7) begin
                        rxd_d   = rxs_q;
                        rxv_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = more ? ST_POP : ST_HOLD;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = {tx_q[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    tx_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rd_en_d = (state_d == ST_POP);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rxs_q   <= '0;
            rxd_q   <= '0;
            cs_n_q  <= 1'b1;
            rd_en_q <= 1'b0;
            rxv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rxs_q   <= rxs_d;
            rxd_q   <= rxd_d;
            cs_n_q  <= cs_n_d;
            rd_en_q <= rd_en_d;
            rxv_q   <= rxv_d;
            busy_q  <= busy_d;
        end
    end

    assign spi_mosi        = tx_q[SPI_BYTE_W-1];
    assign spi_cs_n        = cs_n_q;
    assign fifo.fifo_rd_en = rd_en_q;
    assign rx_data         = rxd_q;
    assign rx_valid        = rxv_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_spi_master_tx_engine.sv
// Bench for spi_master_tx_engine: two instances (CLK_DIV=4 and CLK_DIV=1)
// fed by queue-like FIFO models and watched by an SPI bus monitor.
module tb_spi_master_tx_engine;
    import spi_pkg::*;

    localparam int DA = 4, SA = 2, HA = 2;
    localparam int DB = 1, SB = 1, HB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0] en, miso, sck, mosi, csn, rxv, bsy, rden, empty;
    logic [7:0] rxd [2];
    logic [7:0] rdd [2];

    spi_master_tx_engine_if ifa ();
    spi_master_tx_engine_if ifb ();

    assign ifa.fifo_empty   = empty[0];
    assign ifa.fifo_rd_data = rdd[0];
    assign rden[0]          = ifa.fifo_rd_en;
    assign ifb.fifo_empty   = empty[1];
    assign ifb.fifo_rd_data = rdd[1];
    assign rden[1]          = ifb.fifo_rd_en;

    spi_master_tx_engine #(
        .CLK_DIV (DA), .CS_SETUP (SA), .CS_HOLD (HA)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .en (en[0]), .fifo (ifa.master),
        .spi_miso (miso[0]), .spi_sck (sck[0]), .spi_mosi (mosi[0]),
        .spi_cs_n (csn[0]), .rx_data (rxd[0]), .rx_valid (rxv[0]),
        .busy (bsy[0])
    );

    spi_master_tx_engine #(
        .CLK_DIV (DB), .CS_SETUP (SB), .CS_HOLD (HB)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .en (en[1]), .fifo (ifb.master),
        .spi_miso (miso[1]), .spi_sck (sck[1]), .spi_mosi (mosi[1]),
        .spi_cs_n (csn[1]), .rx_data (rxd[1]), .rx_valid (rxv[1]),
        .busy (bsy[1])
    );

    // FIFO models
    logic [7:0] fmem [2][16];
    int wp [2];
    int rp [2];
    int bad_pop [2];

    always_comb begin
        for (int k = 0; k < 2; k++) empty[k] = (rp[k] == wp[k]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rden[k] === 1'b1 && !empty[k]) begin
                rdd[k] <= fmem[k][rp[k] % 16];
                rp[k]  <= rp[k] + 1;
            end
        end
    end

    // MISO sources: 0 = looped to MOSI, 1 = tied high, 2 = random pattern
    int miso_mode [2];
    logic [7:0] pat [64];
    int nbit [2];
    int nmb [2];

    always_comb begin
        miso = '0;
        for (int k = 0; k < 2; k++) begin
            if (miso_mode[k] == 0) miso[k] = mosi[k];
            else if (miso_mode[k] == 1) miso[k] = 1'b1;
            else miso[k] = pat[nmb[k] % 64][3'(7 - nbit[k])];
        end
    end

    // bus monitor, sampled on the falling clk edge
    int cyc;
    logic [1:0] psck = 2'b00;
    logic [1:0] pcsn = 2'b11;
    logic [7:0] cur [2];
    logic [7:0] mb [2][64];
    logic [7:0] rb [2][64];
    int nrb [2], nrise [2], lowcnt [2], had_rise [2];
    int lr [2][256];
    int nlr [2], first_dly [2], csfall_cyc [2], ncsfall [2], ncsrise [2];
    int hold_len [2], last_fall [2], nrden [2], last_rden [2], lat [2];
    int nrxv [2];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            psck[k] <= sck[k];
            pcsn[k] <= csn[k];
            if (sck[k] === 1'b0) lowcnt[k] <= lowcnt[k] + 1;
            if (csn[k] === 1'b0 && pcsn[k] === 1'b1) begin
                csfall_cyc[k] <= cyc;
                had_rise[k]   <= 0;
                nbit[k]       <= 0;
                ncsfall[k]    <= ncsfall[k] + 1;
            end
            if (csn[k] === 1'b1 && pcsn[k] === 1'b0) begin
                hold_len[k] <= cyc - last_fall[k];
                ncsrise[k]  <= ncsrise[k] + 1;
            end
            if (sck[k] === 1'b0 && psck[k] === 1'b1) last_fall[k] <= cyc;
            if (sck[k] === 1'b1 && psck[k] === 1'b0) begin
                nrise[k]  <= nrise[k] + 1;
                lowcnt[k] <= 0;
                if (had_rise[k] == 0) begin
                    first_dly[k] <= cyc - csfall_cyc[k];
                    had_rise[k]  <= 1;
                end else begin
                    lr[k][nlr[k] % 256] <= lowcnt[k];
                    nlr[k] <= nlr[k] + 1;
                end
                cur[k] <= {cur[k][6:0], mosi[k]};
                if (nbit[k] == 7) begin
                    mb[k][nmb[k] % 64] <= {cur[k][6:0], mosi[k]};
                    nmb[k]  <= nmb[k] + 1;
                    nbit[k] <= 0;
                end else begin
                    nbit[k] <= nbit[k] + 1;
                end
            end
            if (rden[k] === 1'b1) begin
                nrden[k]     <= nrden[k] + 1;
                last_rden[k] <= cyc;
                if (empty[k]) bad_pop[k] <= bad_pop[k] + 1;
            end
            if (rxv[k] === 1'b1) begin
                nrxv[k]            <= nrxv[k] + 1;
                rb[k][nrb[k] % 64] <= rxd[k];
                nrb[k]             <= nrb[k] + 1;
                lat[k]             <= cyc - last_rden[k];
            end
        end
    end

    int npass = 0;
    int ntot  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot += 1;
        assert (obs === exp) npass += 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(int k, logic [7:0] b);
        fmem[k][wp[k] % 16] = b;
        wp[k] = wp[k] + 1;
    endtask

    task automatic wait_idle(int k, int budget, string tag);
        int n = 0;
        step(2);
        while (bsy[k] !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n < budget), 1);
        step(2);
    endtask

    task automatic wait_rises(int k, int target, int budget, string tag);
        int n = 0;
        while (nrise[k] < target && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    // low phase before each rise is d, or d+2 across a byte boundary
    task automatic chk_runs(int k, int b, int n, int d, string tag);
        int bad = 0;
        chk({tag, "_nruns"}, nlr[k] - b, n);
        for (int r = 0; r < n; r++) begin
            if (lr[k][(b + r) % 256] != (((r + 1) % 8 == 0) ? d + 2 : d))
                bad++;
        end
        chk({tag, "_lowrun"}, bad, 0);
    endtask

    int b_mb, b_rb, b_rv, b_rd, b_lr, b_cf, b_cr, b_ri;
    logic [7:0] txv [6];

    task automatic snap(int k);
        b_mb = nmb[k];
        b_rb = nrb[k];
        b_rv = nrxv[k];
        b_rd = nrden[k];
        b_lr = nlr[k];
        b_cf = ncsfall[k];
        b_cr = ncsrise[k];
        b_ri = nrise[k];
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 2'b00;
        miso_mode[0] = 0;
        miso_mode[1] = 1;
        step(3);
        chk("rst_a", {csn[0], sck[0], mosi[0], bsy[0], rxv[0], rden[0]}, 6'b100000);
        chk("rst_b", {csn[1], sck[1], mosi[1], bsy[1], rxv[1], rden[1]}, 6'b100000);
        chk("rst_rxd", rxd[0], 8'h00);
        rst_n = 1'b1;

        // empty FIFO: nothing starts
        en = 2'b11;
        step(30);
        chk("empty_pops", nrden[0] + nrden[1], 0);
        chk("empty_csn", csn, 2'b11);
        chk("empty_busy", bsy, 2'b00);
        en[1] = 1'b0;

        // single byte, loopback
        snap(0);
        push(0, 8'hA5);
        wait_idle(0, 500, "a5_timeout");
        chk("a5_mosi", mb[0][b_mb % 64], 8'hA5);
        chk("a5_rx", rb[0][b_rb % 64], 8'hA5);
        chk("a5_rxv", nrxv[0] - b_rv, 1);
        chk("a5_pops", nrden[0] - b_rd, 1);
        chk("a5_lat", lat[0], 16 * DA + 2);
        chk("a5_setup", first_dly[0], SA + 2 + DA);
        chk("a5_hold", hold_len[0], HA);
        chk_runs(0, b_lr, 7, DA, "a5");

        // three-byte burst
        snap(0);
        push(0, 8'h01);
        push(0, 8'h80);
        push(0, 8'hFF);
        wait_idle(0, 1000, "burst_timeout");
        chk("burst_b0", mb[0][b_mb % 64], 8'h01);
        chk("burst_b1", mb[0][(b_mb + 1) % 64], 8'h80);
        chk("burst_b2", mb[0][(b_mb + 2) % 64], 8'hFF);
        chk("burst_rx2", rb[0][(b_rb + 2) % 64], 8'hFF);
        chk("burst_pops", nrden[0] - b_rd, 3);
        chk("burst_rxv", nrxv[0] - b_rv, 3);
        chk("burst_csfall", ncsfall[0] - b_cf, 1);
        chk("burst_csrise", ncsrise[0] - b_cr, 1);
        chk("burst_stretch", lr[0][(b_lr + 7) % 256], DA + 2);
        chk_runs(0, b_lr, 23, DA, "burst");

        // en dropped during the first of two queued bytes
        snap(0);
        en[0] = 1'b0;
        push(0, 8'h5A);
        push(0, 8'hC3);
        en[0] = 1'b1;
        wait_rises(0, b_ri + 1, 200, "endrop_rise_timeout");
        en[0] = 1'b0;
        wait_idle(0, 500, "endrop_timeout");
        chk("endrop_pops", nrden[0] - b_rd, 1);
        chk("endrop_bytes", nmb[0] - b_mb, 1);
        chk("endrop_mosi", mb[0][b_mb % 64], 8'h5A);
        chk("endrop_hold", hold_len[0], HA);
        chk("endrop_level", wp[0] - rp[0], 1);
        snap(0);
        en[0] = 1'b1;
        wait_idle(0, 500, "drain_timeout");
        chk("drain_mosi", mb[0][b_mb % 64], 8'hC3);
        chk("drain_level", wp[0] - rp[0], 0);

        // reset in the middle of bit 3
        snap(0);
        push(0, 8'hA5);
        wait_rises(0, b_ri + 4, 300, "rstmid_timeout");
        rst_n = 1'b0;
        step(1);
        chk("rstmid_out", {csn[0], sck[0], mosi[0], bsy[0], rxv[0], rden[0]}, 6'b100000);
        chk("rstmid_rxd", rxd[0], 8'h00);
        rst_n = 1'b1;
        step(5);
        chk("rstmid_idle", {csn[0], bsy[0]}, 2'b10);
        chk("rstmid_level", wp[0] - rp[0], 0);
        chk("rstmid_rxv", nrxv[0] - b_rv, 0);

        // random bytes with random MISO pattern
        snap(0);
        miso_mode[0] = 2;
        for (int i = 0; i < 6; i++) begin
            txv[i] = 8'($urandom);
            pat[(b_mb + i) % 64] = 8'($urandom);
        end
        for (int i = 0; i < 6; i++) push(0, txv[i]);
        wait_idle(0, 3000, "rand_timeout");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rand_mosi%0d", i), mb[0][(b_mb + i) % 64], txv[i]);
            chk($sformatf("rand_rx%0d", i), rb[0][(b_rb + i) % 64], pat[(b_mb + i) % 64]);
        end
        chk("rand_pops", nrden[0] - b_rd, 6);
        chk_runs(0, b_lr, 47, DA, "rand");

        // CLK_DIV=1 instance, MISO tied high
        snap(1);
        push(1, 8'h3C);
        en[1] = 1'b1;
        wait_idle(1, 200, "div1_timeout");
        chk("div1_mosi", mb[1][b_mb % 64], 8'h3C);
        chk("div1_rx", rb[1][b_rb % 64], 8'hFF);
        chk("div1_lat", lat[1], 16 * DB + 2);
        chk("div1_setup", first_dly[1], SB + 2 + DB);
        chk("div1_hold", hold_len[1], HB);
        chk("div1_pops", nrden[1] - b_rd, 1);
        chk_runs(1, b_lr, 7, DB, "div1");

        chk("no_empty_pop", bad_pop[0] + bad_pop[1], 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
